// File: rtl/vpu_video_pkg.sv
// Shared video timing defaults, derived frame totals and scanout FSM encoding.
package vpu_video_pkg;

    // 640x480 @ 60 Hz timing (pixel clock ~25.175 MHz)
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // Both counters share one width, sized for the larger total (800 -> 10 bits)
    localparam int unsigned CNT_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StResync    = 2'd0,
        StWaitFrame = 2'd1,
        StRun       = 2'd2
    } scan_state_e;

    // Half-open window test [lo, hi)
    function automatic logic in_window(input cnt_t cnt, input cnt_t lo, input cnt_t hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus active-area and (active-high) sync decode.
module vga_timing_gen
    import vpu_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output cnt_t o_hcount,
    output cnt_t o_vcount,
    output logic o_active,
    output logic o_hsync,
    output logic o_vsync
);

    localparam cnt_t H_LAST    = cnt_t'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam cnt_t V_LAST    = cnt_t'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam cnt_t H_ACT     = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT     = cnt_t'(V_ACTIVE);
    localparam cnt_t H_SYNC_LO = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t H_SYNC_HI = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_SYNC_LO = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t V_SYNC_HI = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t r_hcount;
    cnt_t r_vcount;
    cnt_t w_hcount_next;
    cnt_t w_vcount_next;

    // Next raster position: h wraps every line, v advances on each h wrap
    always_comb begin
        w_hcount_next = r_hcount + 1'b1;
        w_vcount_next = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_next = '0;
            w_vcount_next = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
        end
    end

    // Counter registers, synchronously cleared to the frame origin
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_hcount <= w_hcount_next;
            r_vcount <= w_vcount_next;
        end
    end

    assign o_hcount = r_hcount;
    assign o_vcount = r_vcount;
    assign o_active = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign o_hsync  = in_window(r_hcount, H_SYNC_LO, H_SYNC_HI);
    assign o_vsync  = in_window(r_vcount, V_SYNC_LO, V_SYNC_HI);

endmodule

// File: rtl/vga_scanout_reader.sv
// Pulls pixels from the composer FIFO in lock-step with the VGA raster.
// Resynchronises to the producer's frame_start whenever a frame starves.
module vga_scanout_reader
    import vpu_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [23:0] fifo_q,
    input  logic        fifo_rdempty,
    output logic        fifo_rdreq,
    input  logic        frame_start,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync_n,
    output logic        vga_vsync_n,
    output logic        vga_blank_n,
    output logic [15:0] underflow_count,
    output logic        locked
);

    localparam cnt_t H_LAST = cnt_t'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam cnt_t V_LAST = cnt_t'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);

    cnt_t        w_hcount;
    cnt_t        w_vcount;
    logic        w_active;
    logic        w_hsync;
    logic        w_vsync;

    scan_state_e r_state;
    scan_state_e w_state_next;

    logic        w_origin;
    logic        w_frame_last;
    logic        w_enter_run;
    logic        w_run_active;
    logic        w_pop;
    logic        w_starve;
    logic [23:0] w_color_next;

    logic        r_flag;
    logic [15:0] r_underflow_count;
    logic [23:0] r_color;
    logic        r_hsync_n;
    logic        r_vsync_n;
    logic        r_blank_n;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk    (clk_clk),
        .i_rst    (reset_reset),
        .o_hcount (w_hcount),
        .o_vcount (w_vcount),
        .o_active (w_active),
        .o_hsync  (w_hsync),
        .o_vsync  (w_vsync)
    );

    assign w_origin     = (w_hcount == '0) && (w_vcount == '0);
    assign w_frame_last = (w_hcount == H_LAST) && (w_vcount == V_LAST);
    // The origin pixel is consumed in the same cycle WAIT_FRAME hands over to RUN,
    // so a locked frame always pops every active pixel.
    assign w_enter_run  = (r_state == StWaitFrame) && w_origin && !fifo_rdempty;

    // FSM state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= StResync;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StResync:    if (frame_start) w_state_next = StWaitFrame;
            StWaitFrame: if (w_enter_run) w_state_next = StRun;
            StRun:       if (w_frame_last && r_flag) w_state_next = StResync;
            default:     w_state_next = StResync;
        endcase
    end

    // FSM outputs: FIFO pop, starvation and next pixel colour
    always_comb begin
        w_run_active = w_active && ((r_state == StRun) || w_enter_run);
        w_pop        = 1'b0;
        case (r_state)
            StResync:    w_pop = !fifo_rdempty && !frame_start;
            StWaitFrame,
            StRun:       w_pop = w_run_active && !fifo_rdempty;
            default:     w_pop = 1'b0;
        endcase
        w_starve     = w_run_active && fifo_rdempty;
        w_color_next = (w_run_active && !fifo_rdempty) ? fifo_q : 24'h000000;
    end

    assign fifo_rdreq = w_pop && !reset_reset;

    // Starvation bookkeeping: sticky per-frame flag and saturating counter
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_flag            <= 1'b0;
            r_underflow_count <= 16'h0000;
        end else begin
            if ((r_state == StRun) && w_frame_last && r_flag) begin
                r_flag <= 1'b0;
            end else if (w_starve) begin
                r_flag <= 1'b1;
            end
            if (w_starve && (r_underflow_count != 16'hFFFF)) begin
                r_underflow_count <= r_underflow_count + 1'b1;
            end
        end
    end

    // Registered VGA outputs, one cycle behind the counters
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_color   <= 24'h000000;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_color   <= w_color_next;
            r_hsync_n <= !w_hsync;
            r_vsync_n <= !w_vsync;
            r_blank_n <= w_active;
        end
    end

    assign vga_r           = r_color[23:16];
    assign vga_g           = r_color[15:8];
    assign vga_b           = r_color[7:0];
    assign vga_hsync_n     = r_hsync_n;
    assign vga_vsync_n     = r_vsync_n;
    assign vga_blank_n     = r_blank_n;
    assign underflow_count = r_underflow_count;
    assign locked          = (r_state == StRun);

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader on a shrunken raster (24x10, 16x6 visible).
module tb_vga_scanout_reader;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] fifo_q;
    logic        fifo_rdempty;
    logic        fifo_rdreq;
    logic        frame_start;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hsync_n;
    logic        vga_vsync_n;
    logic        vga_blank_n;
    logic [15:0] underflow_count;
    logic        locked;

    always #5 clk = ~clk;

    vga_scanout_reader #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
    ) dut (
        .clk_clk         (clk),
        .reset_reset     (reset),
        .fifo_q          (fifo_q),
        .fifo_rdempty    (fifo_rdempty),
        .fifo_rdreq      (fifo_rdreq),
        .frame_start     (frame_start),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .vga_hsync_n     (vga_hsync_n),
        .vga_vsync_n     (vga_vsync_n),
        .vga_blank_n     (vga_blank_n),
        .underflow_count (underflow_count),
        .locked          (locked)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Show-ahead FIFO model; 'starve' forces it to look empty
    logic [23:0] mem [0:1023];
    int          wr_ptr    = 0;
    int          rd_ptr    = 0;
    int          pop_count = 0;
    int          bad_pop   = 0;
    bit          starve    = 1'b0;

    assign fifo_rdempty = (rd_ptr == wr_ptr) || starve;
    assign fifo_q       = mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (fifo_rdreq === 1'b1) begin
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
            if (fifo_rdempty) bad_pop <= bad_pop + 1;
        end
    end

    // Raster model: tb_h/tb_v mirror the counters, prev_* is what the outputs show
    int tb_h = 0;
    int tb_v = 0;
    int prev_h = 0;
    int prev_v = 0;

    always @(posedge clk) begin
        if (reset) begin
            tb_h <= 0;
            tb_v <= 0;
        end else begin
            prev_h <= tb_h;
            prev_v <= tb_v;
            if (tb_h == HT - 1) begin
                tb_h <= 0;
                tb_v <= (tb_v == VT - 1) ? 0 : tb_v + 1;
            end else begin
                tb_h <= tb_h + 1;
            end
        end
    end

    // Pixel scoreboard: expected colours queued with the stimulus
    logic [23:0] exp_q [$];
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        logic [23:0] exp_pix;
        if (mon_en && vga_blank_n === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pixel_scoreboard: got %06h at (%0d,%0d), expected no visible pixel",
                         {vga_r, vga_g, vga_b}, prev_h, prev_v);
            end else begin
                exp_pix = exp_q.pop_front();
                if ({vga_r, vga_g, vga_b} !== exp_pix)
                    $display("FAIL pixel_scoreboard: got %06h at (%0d,%0d), expected %06h",
                             {vga_r, vga_g, vga_b}, prev_h, prev_v, exp_pix);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_word(input logic [23:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr++;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tb_h == h && tb_v == v) && n < 4 * HT * VT);
        if (!(tb_h == h && tb_v == v)) begin
            $display("FAIL wait_pos: (%0d,%0d) not reached, at (%0d,%0d)", h, v, tb_h, tb_v);
            $fatal(1, "raster position timeout");
        end
    endtask

    task automatic test_reset();
        int p0;
        reset = 1'b1;
        frame_start = 1'b0;
        push_word(24'h123456);
        push_word(24'h654321);
        push_word(24'hABCDEF);
        repeat (3) @(negedge clk);
        p0 = pop_count;
        n_checks++;
        if (fifo_rdreq !== 1'b0) $display("FAIL reset_rdreq: got %b expected 0", fifo_rdreq);
        else n_pass++;
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0)
            $display("FAIL reset_colour: got %06h expected 000000", {vga_r, vga_g, vga_b});
        else n_pass++;
        n_checks++;
        if ({vga_hsync_n, vga_vsync_n, vga_blank_n} !== 3'b110)
            $display("FAIL reset_syncs: got %b expected 110", {vga_hsync_n, vga_vsync_n, vga_blank_n});
        else n_pass++;
        n_checks++;
        if (underflow_count !== 16'h0) $display("FAIL reset_underflow: got %04h expected 0000", underflow_count);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (pop_count !== p0) $display("FAIL reset_no_pops: got %0d pops expected 0", pop_count - p0);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_sync_timing();
        int hs_err = 0, vs_err = 0, bl_err = 0, col_err = 0, rq_err = 0;
        int hs_low = 0, vs_low = 0, bl_high = 0;
        logic e_hs_n, e_vs_n, e_bl;
        wait_pos(0, 0);
        for (int i = 0; i < HT * VT; i++) begin
            @(negedge clk);
            e_hs_n = !(prev_h >= HA + HFP && prev_h < HA + HFP + HS);
            e_vs_n = !(prev_v >= VA + VFP && prev_v < VA + VFP + VS);
            e_bl   = (prev_h < HA) && (prev_v < VA);
            if (vga_hsync_n !== e_hs_n) hs_err++;
            if (vga_vsync_n !== e_vs_n) vs_err++;
            if (vga_blank_n !== e_bl) bl_err++;
            if (vga_hsync_n === 1'b0) hs_low++;
            if (vga_vsync_n === 1'b0) vs_low++;
            if (vga_blank_n === 1'b1) bl_high++;
            if (vga_blank_n !== 1'b1 && {vga_r, vga_g, vga_b} !== 24'h0) col_err++;
            if (fifo_rdreq !== 1'b0) rq_err++;
        end
        n_checks++;
        if (hs_err != 0) $display("FAIL hsync_pattern: got %0d bad cycles expected 0", hs_err);
        else n_pass++;
        n_checks++;
        if (vs_err != 0) $display("FAIL vsync_pattern: got %0d bad cycles expected 0", vs_err);
        else n_pass++;
        n_checks++;
        if (bl_err != 0) $display("FAIL blank_pattern: got %0d bad cycles expected 0", bl_err);
        else n_pass++;
        n_checks++;
        if (hs_low != VT * HS) $display("FAIL hsync_low_count: got %0d expected %0d", hs_low, VT * HS);
        else n_pass++;
        n_checks++;
        if (vs_low != VS * HT) $display("FAIL vsync_low_count: got %0d expected %0d", vs_low, VS * HT);
        else n_pass++;
        n_checks++;
        if (bl_high != NPIX) $display("FAIL blank_high_count: got %0d expected %0d", bl_high, NPIX);
        else n_pass++;
        n_checks++;
        if (col_err != 0) $display("FAIL colour_in_blank: got %0d bad cycles expected 0", col_err);
        else n_pass++;
        n_checks++;
        if (rq_err != 0) $display("FAIL resync_empty_rdreq: got %0d pops expected 0", rq_err);
        else n_pass++;
    endtask

    task automatic test_run_frame();
        int p0;
        logic [23:0] w;
        wait_pos(3, 7);
        p0 = pop_count;
        for (int i = 0; i < NPIX; i++) begin
            w = 24'(i);
            push_word(w);
            exp_q.push_back(w);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;  // ignored in WAIT_FRAME
        @(negedge clk);
        frame_start = 1'b0;
        wait_pos(0, 0);
        n_checks++;
        if (pop_count !== p0) $display("FAIL wait_frame_no_pops: got %0d pops expected 0", pop_count - p0);
        else n_pass++;
        n_checks++;
        if (fifo_rdreq !== 1'b1) $display("FAIL origin_pop: got %b expected 1", fifo_rdreq);
        else n_pass++;
        mon_en = 1'b1;
        wait_pos(1, 0);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL run_locked: got %b expected 1", locked);
        else n_pass++;
        n_checks++;
        if ({vga_blank_n, vga_r, vga_g, vga_b} !== 25'h1000000)
            $display("FAIL first_pixel: got blank_n=%b %06h expected blank_n=1 000000",
                     vga_blank_n, {vga_r, vga_g, vga_b});
        else n_pass++;
        wait_pos(5, 2);
        frame_start = 1'b1;  // ignored in RUN
        @(negedge clk);
        frame_start = 1'b0;
        wait_pos(16, 5);
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 24'(NPIX - 1))
            $display("FAIL last_pixel: got %06h expected %06h", {vga_r, vga_g, vga_b}, 24'(NPIX - 1));
        else n_pass++;
        wait_pos(0, 6);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL frame_pixels_left: got %0d expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (pop_count - p0 != NPIX) $display("FAIL frame_pops: got %0d expected %0d", pop_count - p0, NPIX);
        else n_pass++;
        n_checks++;
        if (underflow_count !== 16'h0) $display("FAIL frame_underflow: got %04h expected 0000", underflow_count);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL frame_start_ignored: got locked=%b expected 1", locked);
        else n_pass++;
    endtask

    task automatic test_underflow();
        int p0, j, rq_err;
        p0 = pop_count;
        rq_err = 0;
        for (int i = 0; i < NPIX; i++) push_word(24'h010000 + 24'(i));
        j = 0;
        for (int v = 0; v < VA; v++) begin
            for (int h = 0; h < HA; h++) begin
                if (v == 2 && h >= 4 && h < 9) begin
                    exp_q.push_back(24'h000000);
                end else begin
                    exp_q.push_back(24'h010000 + 24'(j));
                    j++;
                end
            end
        end
        wait_pos(4, 2);
        for (int k = 0; k < 5; k++) begin
            starve = 1'b1;
            #1;
            if (fifo_rdreq !== 1'b0) rq_err++;
            @(negedge clk);
        end
        starve = 1'b0;
        n_checks++;
        if (rq_err != 0) $display("FAIL starve_rdreq: got %0d pops while empty expected 0", rq_err);
        else n_pass++;
        wait_pos(0, 6);
        mon_en = 1'b0;
        n_checks++;
        if (underflow_count !== 16'd5) $display("FAIL underflow_count: got %0d expected 5", underflow_count);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL starve_pixels_left: got %0d expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (pop_count - p0 != NPIX - 5) $display("FAIL starve_pops: got %0d expected %0d", pop_count - p0, NPIX - 5);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL starve_still_locked: got %b expected 1", locked);
        else n_pass++;
        wait_pos(0, 0);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL starve_resync: got locked=%b expected 0", locked);
        else n_pass++;
        repeat (8) @(negedge clk);
        n_checks++;
        if (pop_count - p0 != NPIX) $display("FAIL resync_drain_left: got %0d pops expected %0d", pop_count - p0, NPIX);
        else n_pass++;
    endtask

    task automatic test_resync_drain(output int f_base);
        int p0, p1;
        p0 = pop_count;
        for (int i = 0; i < 100; i++) push_word(24'hA00000 + 24'(i));
        repeat (110) @(negedge clk);
        n_checks++;
        if (pop_count - p0 != 100) $display("FAIL stale_drain: got %0d pops expected 100", pop_count - p0);
        else n_pass++;
        p1 = pop_count;
        for (int i = 0; i < NPIX; i++) push_word(24'h020000 + 24'(i));
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_pos(0, 0);
        n_checks++;
        if (pop_count !== p1) $display("FAIL no_pop_before_origin: got %0d pops expected 0", pop_count - p1);
        else n_pass++;
        n_checks++;
        if (fifo_rdreq !== 1'b1) $display("FAIL resync_origin_pop: got %b expected 1", fifo_rdreq);
        else n_pass++;
        f_base = p1;
    endtask

    task automatic test_reset_mid_frame(input int f_base);
        int p0, lk_err;
        lk_err = 0;
        wait_pos(10, 3);
        reset = 1'b1;
        #1;
        n_checks++;
        if (fifo_rdreq !== 1'b0) $display("FAIL midreset_rdreq: got %b expected 0", fifo_rdreq);
        else n_pass++;
        p0 = pop_count;
        @(negedge clk);
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0)
            $display("FAIL midreset_colour: got %06h expected 000000", {vga_r, vga_g, vga_b});
        else n_pass++;
        n_checks++;
        if ({vga_hsync_n, vga_vsync_n, vga_blank_n} !== 3'b110)
            $display("FAIL midreset_syncs: got %b expected 110", {vga_hsync_n, vga_vsync_n, vga_blank_n});
        else n_pass++;
        n_checks++;
        if ({locked, underflow_count} !== 17'h0)
            $display("FAIL midreset_state: got locked=%b uf=%04h expected 0 0000", locked, underflow_count);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pop_count !== p0) $display("FAIL midreset_no_pops: got %0d pops expected 0", pop_count - p0);
        else n_pass++;
        reset = 1'b0;
        repeat (HT * VT + 40) begin
            @(negedge clk);
            if (locked !== 1'b0) lk_err++;
        end
        n_checks++;
        if (lk_err != 0) $display("FAIL relock_without_frame_start: got %0d locked cycles expected 0", lk_err);
        else n_pass++;
        n_checks++;
        if (pop_count - f_base != NPIX)
            $display("FAIL midreset_total_pops: got %0d expected %0d", pop_count - f_base, NPIX);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < NPIX; i++) push_word(24'h030000 + 24'(i));
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_pos(0, 0);
        wait_pos(0, 1);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL sat_locked: got %b expected 1", locked);
        else n_pass++;
        force dut.r_underflow_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_underflow_count;
        wait_pos(0, 2);
        for (int k = 0; k < 3; k++) begin
            starve = 1'b1;
            @(negedge clk);
        end
        starve = 1'b0;
        n_checks++;
        if (underflow_count !== 16'hFFFF) $display("FAIL underflow_saturate: got %04h expected ffff", underflow_count);
        else n_pass++;
    endtask

    initial begin
        int f_base;
        test_reset();
        test_sync_timing();
        test_run_frame();
        test_underflow();
        test_resync_drain(f_base);
        test_reset_mid_frame(f_base);
        test_saturation();
        n_checks++;
        if (bad_pop != 0) $display("FAIL pop_while_empty: got %0d expected 0", bad_pop);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
